// File: rtl/bip_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bip_pkg: shared opcodes, SelA encodings, FSM states and control bundle    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;

    localparam logic [1:0] SELA_RAM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    localparam logic [1:0] S_EXEC    = 2'd0;
    localparam logic [1:0] S_LOAD_WB = 2'd1;
    localparam logic [1:0] S_HALT    = 2'd2;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_hlt;
        logic       is_ld;
        logic       is_jmp;
        logic       is_beq;
        logic       is_bne;
        logic       legal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/bip_control_unit_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bip_opcode_decoder: combinational opcode -> control bundle + legal flag   |
// | Branch opcodes decode only when BIP_BRANCH_EN is defined.                 |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module bip_opcode_decoder
    import bip_pkg::*;
#(
    parameter int NB_OPCODE = 5
) (
    input  logic [NB_OPCODE-1:0] i_opcode,
    output ctrl_t                o_ctrl
);

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.legal = 1'b1;
        case (i_opcode)
            NB_OPCODE'(OP_HLT):  o_ctrl.is_hlt = 1'b1;
            NB_OPCODE'(OP_STO):  o_ctrl.wr_ram = 1'b1;
            NB_OPCODE'(OP_LD): begin
                o_ctrl.is_ld  = 1'b1;
                o_ctrl.rd_ram = 1'b1;
            end
            NB_OPCODE'(OP_LDI): begin
                o_ctrl.sel_a  = SELA_IMM;
                o_ctrl.wr_acc = 1'b1;
            end
            NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
                o_ctrl.rd_ram = 1'b1;
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.op     = (i_opcode == NB_OPCODE'(OP_SUB));
            end
            NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
                o_ctrl.sel_b  = 1'b1;
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.op     = (i_opcode == NB_OPCODE'(OP_SUBI));
            end
`ifdef BIP_BRANCH_EN
            NB_OPCODE'(OP_JMP):  o_ctrl.is_jmp = 1'b1;
            NB_OPCODE'(OP_BEQ):  o_ctrl.is_beq = 1'b1;
            NB_OPCODE'(OP_BNE):  o_ctrl.is_bne = 1'b1;
`endif
            default:             o_ctrl.legal  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bip_control_unit: BIP program counter, execution FSM and strobe decode    |
// | Define BIP_BRANCH_EN to enable JMP/BEQ/BNE.                               |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int NB_INSTR  = 16,
    parameter int NB_OPCODE = 5,
    parameter int NB_ADDR   = 11
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_en,
    input  logic [NB_INSTR-1:0]           i_Instruction,
    input  logic                          i_AccZero,
    output logic [NB_ADDR-1:0]            o_Addr,
    output logic [NB_INSTR-NB_OPCODE-1:0] o_Operand,
    output logic [1:0]                    o_SelA,
    output logic                          o_SelB,
    output logic                          o_WrAcc,
    output logic                          o_Op,
    output logic                          o_WrRam,
    output logic                          o_RdRam,
    output logic                          o_Halted,
    output logic                          o_IllegalOp
);

    localparam int NB_OPERAND = NB_INSTR - NB_OPCODE;

    logic [1:0]         r_state;
    logic [NB_ADDR-1:0] r_pc;
    logic [1:0]         w_next_state;
    logic [NB_ADDR-1:0] w_next_pc;
    logic [NB_ADDR-1:0] w_pc_inc;
    logic               w_run;
    ctrl_t              w_dec;

    bip_opcode_decoder #(
        .NB_OPCODE (NB_OPCODE)
    ) u_decoder (
        .i_opcode (i_Instruction[NB_INSTR-1 -: NB_OPCODE]),
        .o_ctrl   (w_dec)
    );

    assign w_run    = i_en & ~i_reset;
    assign w_pc_inc = r_pc + NB_ADDR'(1);

`ifdef BIP_BRANCH_EN
    logic w_take_branch;
    assign w_take_branch = w_dec.is_jmp
                         | (w_dec.is_beq &  i_AccZero)
                         | (w_dec.is_bne & ~i_AccZero);
`else
    logic w_unused_branch;
    assign w_unused_branch = ^{i_AccZero, w_dec.is_jmp, w_dec.is_beq, w_dec.is_bne};
`endif

    // Everything below defaults to "hold / no strobe", so a stall or reset needs no extra gating.
    always_comb begin
        o_SelA       = SELA_RAM;
        o_SelB       = 1'b0;
        o_Op         = 1'b0;
        o_WrAcc      = 1'b0;
        o_WrRam      = 1'b0;
        o_RdRam      = 1'b0;
        o_IllegalOp  = 1'b0;
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if (w_run) begin
            case (r_state)
                S_EXEC: begin
                    if (!w_dec.legal) begin
                        o_IllegalOp = 1'b1;
                        w_next_pc   = w_pc_inc;
                    end else begin
                        o_SelA  = w_dec.sel_a;
                        o_SelB  = w_dec.sel_b;
                        o_Op    = w_dec.op;
                        o_WrAcc = w_dec.wr_acc;
                        o_WrRam = w_dec.wr_ram;
                        o_RdRam = w_dec.rd_ram;
                        if (w_dec.is_hlt) begin
                            w_next_state = S_HALT;
                        end else if (w_dec.is_ld) begin
                            w_next_state = S_LOAD_WB;
`ifdef BIP_BRANCH_EN
                        end else if (w_take_branch) begin
                            w_next_pc = i_Instruction[NB_ADDR-1:0];
`endif
                        end else begin
                            w_next_pc = w_pc_inc;
                        end
                    end
                end
                S_LOAD_WB: begin
                    // RAM data arrives one cycle after the read strobe.
                    o_SelA       = SELA_RAM;
                    o_WrAcc      = 1'b1;
                    w_next_state = S_EXEC;
                    w_next_pc    = w_pc_inc;
                end
                S_HALT: begin
                    w_next_state = S_HALT;
                end
                default: begin
                    w_next_state = S_EXEC;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_EXEC;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    assign o_Addr    = r_pc;
    assign o_Operand = i_reset ? '0 : i_Instruction[NB_OPERAND-1:0];
    assign o_Halted  = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bip_control_unit: vector tables plus randomized run against an ISA     |
// | level reference model. Rev 1.0 - initial release                          |
// +--------------------------------------------------------------------------+
module tb_bip_control_unit;

`ifdef BIP_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] addr;
        logic [10:0] operand;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
        logic        wracc;
        logic        wrram;
        logic        rdram;
        logic        halted;
        logic        ill;
    } obs_t;

    typedef struct {
        logic rst;
        logic en;
        logic accz;
        obs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, accz;
    logic [15:0] instr;
    logic [10:0] addr, operand;
    logic [1:0]  sela;
    logic        selb, wracc, op, wrram, rdram, halted, ill;

    logic [15:0] imem [0:2047];
    vec_t        vq [$];
    int          tests = 0;
    int          fails = 0;

    logic [10:0] m_pc, n_pc;
    bit          m_wb, m_halt, n_wb, n_halt;

    always #5 clk = ~clk;
    assign instr = imem[addr];

    bip_control_unit dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_Instruction (instr),
        .i_AccZero     (accz),
        .o_Addr        (addr),
        .o_Operand     (operand),
        .o_SelA        (sela),
        .o_SelB        (selb),
        .o_WrAcc       (wracc),
        .o_Op          (op),
        .o_WrRam       (wrram),
        .o_RdRam       (rdram),
        .o_Halted      (halted),
        .o_IllegalOp   (ill)
    );

    function automatic logic [15:0] mk(input logic [4:0] opc, input int opd);
        return {opc, 11'(opd)};
    endfunction

    function automatic vec_t V(input logic r, input logic e, input logic z,
                               input int a, input int opd, input int sa, input int sb,
                               input int o, input int wa, input int wr, input int rd,
                               input int h, input int il);
        vec_t v;
        v.rst = r; v.en = e; v.accz = z;
        v.exp = {11'(a), 11'(opd), 2'(sa), 1'(sb), 1'(o), 1'(wa), 1'(wr), 1'(rd), 1'(h), 1'(il)};
        return v;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("addr=%0d opnd=%0d selA=%0d selB=%0d op=%0d wrAcc=%0d wrRam=%0d rdRam=%0d halted=%0d ill=%0d",
                         o.addr, o.operand, o.sela, o.selb, o.op, o.wracc, o.wrram, o.rdram, o.halted, o.ill);
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = {addr, operand, sela, selb, op, wracc, wrram, rdram, halted, ill};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %s | expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic clear_imem(input logic [15:0] fill);
        for (int a = 0; a < 2048; a++) imem[a] = fill;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; accz = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_vecs(input string name);
        do_reset();
        for (int k = 0; k < vq.size(); k++) begin
            rst = vq[k].rst; en = vq[k].en; accz = vq[k].accz;
            #1;
            check($sformatf("%s[%0d]", name, k), vq[k].exp);
            @(posedge clk); #1;
        end
        vq.delete();
    endtask

    // Instruction-level semantics: what one clock should show, and where the machine goes next.
    task automatic model_step(input logic [15:0] ins, input bit r, input bit e, input bit z,
                              output obs_t x);
        logic [4:0] opc;
        bit         taken;
        opc = ins[15:11];
        x = '0;
        x.addr = m_pc; x.halted = m_halt;
        n_pc = m_pc; n_wb = m_wb; n_halt = m_halt;
        if (r) begin
            n_pc = '0; n_wb = 1'b0; n_halt = 1'b0;
            return;
        end
        x.operand = ins[10:0];
        if (!e || m_halt) return;
        if (m_wb) begin
            x.wracc = 1'b1; n_wb = 1'b0; n_pc = 11'(m_pc + 11'd1);
            return;
        end
        n_pc = 11'(m_pc + 11'd1);
        case (opc)
            5'd0: begin n_halt = 1'b1; n_pc = m_pc; end
            5'd1: x.wrram = 1'b1;
            5'd2: begin x.rdram = 1'b1; n_wb = 1'b1; n_pc = m_pc; end
            5'd3: begin x.sela = 2'd1; x.wracc = 1'b1; end
            5'd4, 5'd6: begin x.rdram = 1'b1; x.sela = 2'd2; x.wracc = 1'b1; x.op = (opc == 5'd6); end
            5'd5, 5'd7: begin x.selb = 1'b1; x.sela = 2'd2; x.wracc = 1'b1; x.op = (opc == 5'd7); end
            5'd8, 5'd9, 5'd10: begin
                if (BR) begin
                    taken = (opc == 5'd10) || (opc == 5'd8 && z) || (opc == 5'd9 && !z);
                    if (taken) n_pc = ins[10:0];
                end else begin
                    x.ill = 1'b1;
                end
            end
            default: x.ill = 1'b1;
        endcase
    endtask

    initial begin
        obs_t e;
        int   halt_cnt;
        logic [4:0] ops [13];
        ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd31, 5'd12, 5'd20};

        // Program: LDI 5; ADDI 3; STO 7; HLT, then reset out of HALT.
        clear_imem(16'h0000);
        imem[0] = mk(5'd3, 5); imem[1] = mk(5'd5, 3); imem[2] = mk(5'd1, 7);
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,5, 1,0,0, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 1,3, 2,1,0, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 2,7, 0,0,0, 0,1,0, 0,0));
        vq.push_back(V(0,1,0, 3,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 3,0, 0,0,0, 0,0,0, 1,0));
        vq.push_back(V(0,1,0, 3,0, 0,0,0, 0,0,0, 1,0));
        vq.push_back(V(1,1,0, 3,0, 0,0,0, 0,0,0, 1,0));
        vq.push_back(V(0,0,0, 0,5, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,5, 1,0,0, 1,0,0, 0,0));
        run_vecs("prog_ldi");

        // LD, LD with stalled writeback, illegal opcode, stalled ADDI stream, SUB/SUBI/ADD.
        clear_imem(16'h0000);
        imem[0] = mk(5'd2, 4); imem[1] = mk(5'd2, 4); imem[2] = 16'hF800;
        imem[3] = mk(5'd5, 1); imem[4] = mk(5'd5, 2); imem[5] = mk(5'd6, 6);
        imem[6] = mk(5'd7, 9); imem[7] = mk(5'd4, 1);
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,4, 0,0,0, 0,0,1, 0,0));
        vq.push_back(V(0,1,0, 0,4, 0,0,0, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 1,4, 0,0,0, 0,0,1, 0,0));
        for (int k = 0; k < 3; k++) vq.push_back(V(0,0,0, 1,4, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 1,4, 0,0,0, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 2,0, 0,0,0, 0,0,0, 0,1));
        vq.push_back(V(0,1,0, 3,1, 2,1,0, 1,0,0, 0,0));
        for (int k = 0; k < 4; k++) vq.push_back(V(0,0,0, 4,2, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 4,2, 2,1,0, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 5,6, 2,0,1, 1,0,1, 0,0));
        vq.push_back(V(0,1,0, 6,9, 2,1,1, 1,0,0, 0,0));
        vq.push_back(V(0,1,0, 7,1, 2,0,0, 1,0,1, 0,0));
        vq.push_back(V(0,1,0, 8,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 8,0, 0,0,0, 0,0,0, 1,0));
        run_vecs("prog_ld");

        // Reset arriving during the LD writeback cycle.
        clear_imem(16'h0000);
        imem[0] = mk(5'd2, 4);
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,4, 0,0,0, 0,0,1, 0,0));
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,4, 0,0,0, 0,0,1, 0,0));
        vq.push_back(V(0,1,0, 0,4, 0,0,0, 1,0,0, 0,0));
        run_vecs("rst_mid_ld");

        // Branch opcodes.
        clear_imem(16'h0000);
        imem[0] = mk(5'd8, 10); imem[1] = mk(5'd9, 5);
`ifdef BIP_BRANCH_EN
        imem[10] = mk(5'd9, 20); imem[11] = mk(5'd10, 0);
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,1, 0,10, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,1, 10,20, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 11,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 0,10, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 1,5, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 5,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 5,0, 0,0,0, 0,0,0, 1,0));
`else
        imem[2] = mk(5'd10, 0);
        vq.push_back(V(1,1,0, 0,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,1, 0,10, 0,0,0, 0,0,0, 0,1));
        vq.push_back(V(0,1,1, 1,5, 0,0,0, 0,0,0, 0,1));
        vq.push_back(V(0,1,0, 2,0, 0,0,0, 0,0,0, 0,1));
        vq.push_back(V(0,1,0, 3,0, 0,0,0, 0,0,0, 0,0));
        vq.push_back(V(0,1,0, 3,0, 0,0,0, 0,0,0, 1,0));
`endif
        run_vecs("branch");

        // PC wrap: 2047 ADDI steps reach the top address, one more wraps to 0.
        clear_imem(mk(5'd5, 0));
        do_reset();
        rst = 1'b0; en = 1'b1;
        repeat (2047) @(posedge clk);
        #1;
        tests++;
        if (addr !== 11'd2047) begin
            fails++;
            $display("FAIL pc_top: got addr=%0d expected 2047", addr);
        end
        @(posedge clk); #1;
        tests++;
        if (addr !== 11'd0) begin
            fails++;
            $display("FAIL pc_wrap: got addr=%0d expected 0", addr);
        end

        // Randomized program and control inputs against the reference model.
        for (int a = 0; a < 2048; a++)
            imem[a] = ($urandom_range(0, 49) == 0) ? mk(5'd0, $urandom_range(0, 2047))
                                                   : mk(ops[$urandom_range(0, 12)], $urandom_range(0, 2047));
        do_reset();
        m_pc = '0; m_wb = 1'b0; m_halt = 1'b0;
        halt_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 63) == 0) || (m_halt && halt_cnt > 3);
            en   = ($urandom_range(0, 3) != 0);
            accz = 1'($urandom_range(0, 1));
            #1;
            model_step(imem[m_pc], rst, en, accz, e);
            check("random", e);
            @(posedge clk); #1;
            m_pc = n_pc; m_wb = n_wb; m_halt = n_halt;
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
